bfp_block_normalizer: RTL and testbench

Consumer side of the block-floating-point minimum-LZC detector. Accepts 16 signed lanes per beat and drives the detector's enable. Reads the block-minimum redundant-sign-bit count one cycle later and left-shifts all 16 lanes by it. Emits normalized blocks with a per-frame running block exponent through a valid/ready output buffer to the next FFT stage.

---
 rtl/bfp_block_normalizer.sv | 136 +++++++++++++
 tb/tb_bfp_block_normalizer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bfp_block_normalizer.sv
// Block-floating-point normalizer: left-shifts each 16-lane block by its
// minimum redundant-sign-bit count and tracks a per-frame block exponent.
module bfp_block_normalizer #(
    parameter int DATA_W           = 16,
    parameter int LZC_WIDTH        = 5,
    parameter int MAX_SHIFT        = 15,
    parameter int EXP_W            = 6,
    parameter int BLOCKS_PER_FRAME = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data [0:15],
    output logic                 lzc_en,
    input  logic [LZC_WIDTH-1:0] min_lzc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data [0:15],
    output logic [LZC_WIDTH-1:0] out_shift,
    output logic [EXP_W-1:0]     out_exp,
    output logic                 out_last
);

    localparam int LANES = 16;
    localparam int CNT_W = $clog2(BLOCKS_PER_FRAME);
    localparam int SUM_W = ((EXP_W > LZC_WIDTH) ? EXP_W : LZC_WIDTH) + 1;
    localparam logic [LZC_WIDTH-1:0] MAX_SH   = LZC_WIDTH'(MAX_SHIFT);
    localparam logic [SUM_W-1:0]     EXP_MAX  = SUM_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0]     LAST_BLK = CNT_W'(BLOCKS_PER_FRAME - 1);

    logic                 r_s1_valid;
    logic [DATA_W-1:0]    r_s1_data [0:LANES-1];

    logic [DATA_W-1:0]    r_fifo_data  [0:2][0:LANES-1];
    logic [LZC_WIDTH-1:0] r_fifo_shift [0:2];
    logic [EXP_W-1:0]     r_fifo_exp   [0:2];
    logic                 r_fifo_last  [0:2];
    logic [1:0]           r_rd_ptr;
    logic [1:0]           r_wr_ptr;
    logic [1:0]           r_count;

    logic [CNT_W-1:0]     r_blk_cnt;
    logic [EXP_W-1:0]     r_acc;

    logic                 w_push;
    logic                 w_pop;
    logic [2:0]           w_occ;
    logic [LZC_WIDTH-1:0] w_sh;
    logic [SUM_W-1:0]     w_sum;
    logic [EXP_W-1:0]     w_exp;
    logic                 w_last;
    logic [DATA_W-1:0]    w_lanes [0:LANES-1];

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit check counts the beat in S1, so every accepted beat has a slot
    assign w_occ     = {1'b0, r_count} + {2'b00, r_s1_valid};
    assign in_ready  = !rst && (w_occ < 3'd3);
    assign lzc_en    = in_valid && in_ready;
    assign out_valid = !rst && (r_count != 2'd0);
    assign w_push    = r_s1_valid;
    assign w_pop     = out_valid && out_ready;

    assign w_sh   = (min_lzc > MAX_SH) ? MAX_SH : min_lzc;
    assign w_sum  = SUM_W'(r_acc) + SUM_W'(w_sh);
    assign w_exp  = (w_sum > EXP_MAX) ? EXP_W'(EXP_MAX) : w_sum[EXP_W-1:0];
    assign w_last = (r_blk_cnt == LAST_BLK);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_lanes[i] = r_s1_data[i] << w_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_blk_cnt  <= '0;
            r_acc      <= '0;
        end else begin
            r_s1_valid <= lzc_en;
            if (w_push) begin
                r_wr_ptr  <= ptr_inc(r_wr_ptr);
                r_blk_cnt <= r_blk_cnt + CNT_W'(1);
                r_acc     <= w_last ? '0 : w_exp;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (lzc_en) begin
            r_s1_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= w_lanes;
            r_fifo_shift[r_wr_ptr] <= w_sh;
            r_fifo_exp[r_wr_ptr]   <= w_exp;
            r_fifo_last[r_wr_ptr]  <= w_last;
        end
    end

    always_comb begin
        out_shift = '0;
        out_exp   = '0;
        out_last  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            out_data[i] = '0;
        end
        if (out_valid) begin
            out_shift = r_fifo_shift[r_rd_ptr];
            out_exp   = r_fifo_exp[r_rd_ptr];
            out_last  = r_fifo_last[r_rd_ptr];
            for (int i = 0; i < LANES; i++) begin
                out_data[i] = r_fifo_data[r_rd_ptr][i];
            end
        end
    end

endmodule

// File: tb/tb_bfp_block_normalizer.sv
// Randomized bench for bfp_block_normalizer with a queue-based reference
// model of shifts, frame exponents and output order.
module tb_bfp_block_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, lzc_en, out_valid, out_last;
    logic [15:0] in_data  [0:15];
    logic [15:0] out_data [0:15];
    logic [4:0]  min_lzc = 5'd0;
    logic [4:0]  out_shift;
    logic [5:0]  out_exp;

    always #5 clk = ~clk;

    bfp_block_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lzc_en(lzc_en), .min_lzc(min_lzc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shift(out_shift), .out_exp(out_exp), .out_last(out_last)
    );

    typedef struct packed {
        logic [15:0][15:0] d;
        logic [4:0]        sh;
        logic [5:0]        e;
        logic              last;
        int                vis;
    } ent_t;

    ent_t        q[$];
    int          m_acc = 0;
    int          m_blk = 0;
    int          cyc = 0;
    bit          pend = 0;
    logic [4:0]  pend_lzc = 0;
    bit          last_acc = 0;
    logic [15:0] stim [0:15];
    int          passes = 0;
    int          checks = 0;
    int          rexp[$];
    int          rlast[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint a, input longint e);
        checks++;
        if (a == e) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    endtask

    // Reference: shift clamp, truncating shift, saturating frame sum
    task automatic model_push(input logic [4:0] l);
        ent_t e;
        int   sh, s;
        sh = (l > 15) ? 15 : int'(l);
        for (int i = 0; i < 16; i++) e.d[i] = 16'(in_data[i] << sh);
        s = m_acc + sh;
        if (s > 63) s = 63;
        e.sh   = 5'(sh);
        e.e    = 6'(s);
        e.last = (m_blk == 31);
        e.vis  = cyc + 2;
        m_acc  = e.last ? 0 : s;
        m_blk  = (m_blk + 1) % 32;
        q.push_back(e);
    endtask

    task automatic tick(input bit v, input bit r, input logic [4:0] l, input bit rs);
        rst       = rs;
        in_valid  = v;
        out_ready = r;
        for (int i = 0; i < 16; i++) in_data[i] = stim[i];
        min_lzc = pend ? pend_lzc : 5'($urandom);
        @(negedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_acc = 0; m_blk = 0; pend = 0; last_acc = 0;
        end else begin
            last_acc = in_valid && in_ready;
            pend     = last_acc;
            if (last_acc) begin
                pend_lzc = l;
                model_push(l);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_stim();
        for (int i = 0; i < 16; i++) stim[i] = 16'($urandom);
    endtask

    task automatic do_reset();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
    endtask

    task automatic run_frame(input logic [4:0] l, output int nacc);
        do_reset();
        rexp.delete();
        rlast.delete();
        nacc = 0;
        for (int k = 0; k < 37; k++) begin
            rand_stim();
            tick(k < 33, 1, l, 0);
            if (k < 33) nacc += int'(last_acc);
            if (out_valid && out_ready) begin
                rexp.push_back(int'(out_exp));
                rlast.push_back(int'(out_last));
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        bit er;
        bit ev;
        er = !rst && (q.size() < 3);
        chk("in_ready", in_ready, er);
        chk("lzc_en", lzc_en, in_valid && er);
        chk("occupancy", q.size() <= 3, 1);
        ev = !rst && (q.size() > 0) && (q[0].vis <= cyc);
        chk("out_valid", out_valid, ev);
        if (rst) begin
            chk("rst_shift", out_shift, 0);
            chk("rst_exp", out_exp, 0);
            chk("rst_last", out_last, 0);
            chk("rst_data0", out_data[0], 0);
        end
        if (ev && out_valid) begin
            for (int i = 0; i < 16; i++) chk("out_data", out_data[i], q[0].d[i]);
            chk("out_shift", out_shift, q[0].sh);
            chk("out_exp", out_exp, q[0].e);
            chk("out_last", out_last, q[0].last);
            if (out_ready) void'(q.pop_front());
        end
    end

    initial begin
        int n;
        int nl;
        for (int i = 0; i < 16; i++) stim[i] = 16'h0;
        for (int i = 0; i < 16; i++) in_data[i] = 16'h0;

        do_reset();
        for (int i = 0; i < 16; i++) stim[i] = 16'h0012;
        tick(1, 1, 5'd10, 0);
        chk("t1_accept_after_rst", last_acc, 1);
        chk("t1_not_yet_valid", out_valid, 0);
        tick(0, 1, 0, 0);
        chk("t1_valid_T2", out_valid, 1);
        chk("t1_data0", out_data[0], 16'h4800);
        chk("t1_data15", out_data[15], 16'h4800);
        chk("t1_shift", out_shift, 10);
        chk("t1_exp", out_exp, 10);

        for (int i = 0; i < 16; i++) stim[i] = 16'hFFF0;
        tick(1, 1, 5'd11, 0);
        tick(0, 1, 0, 0);
        chk("t2_data3", out_data[3], 16'h8000);
        chk("t2_shift", out_shift, 11);

        for (int i = 0; i < 16; i++) stim[i] = 16'h0;
        stim[0] = 16'h0100;
        stim[1] = 16'hFF00;
        tick(1, 1, 5'd7, 0);
        tick(0, 1, 0, 0);
        chk("t3_data0", out_data[0], 16'h8000);
        chk("t3_data1", out_data[1], 16'h8000);
        chk("t3_data2", out_data[2], 16'h0000);
        chk("t3_shift", out_shift, 7);

        run_frame(5'd1, n);
        chk("f1_accepted", n, 33);
        chk("f1_count", rexp.size(), 33);
        chk("f1_exp_b1", rexp[0], 1);
        chk("f1_exp_b32", rexp[31], 32);
        chk("f1_last_b32", rlast[31], 1);
        nl = 0;
        for (int k = 0; k < 31; k++) nl += rlast[k];
        chk("f1_no_early_last", nl, 0);
        chk("f1_exp_next", rexp[32], 1);
        chk("f1_last_next", rlast[32], 0);

        run_frame(5'd15, n);
        chk("f2_exp_b4", rexp[3], 60);
        chk("f2_exp_b5", rexp[4], 63);
        chk("f2_exp_b32", rexp[31], 63);
        chk("f2_exp_next", rexp[32], 15);

        do_reset();
        n = 0;
        for (int k = 0; k < 6; k++) begin
            rand_stim();
            tick(1, 0, 5'($urandom_range(0, 15)), 0);
            n += int'(last_acc);
        end
        chk("stall_accepted", n, 3);
        chk("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 4; k++) tick(0, 1, 0, 0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            rand_stim();
            tick(1, 1, 5'($urandom_range(0, 15)), 0);
            n += int'(last_acc);
        end
        chk("resume_accepted", n, 4);
        for (int k = 0; k < 4; k++) tick(0, 1, 0, 0);

        do_reset();
        for (int k = 0; k < 3; k++) begin
            rand_stim();
            tick(1, 0, 5'd3, 0);
        end
        tick(0, 0, 0, 1);
        chk("rst_mid_valid", out_valid, 0);
        tick(0, 1, 0, 0);
        for (int i = 0; i < 16; i++) stim[i] = 16'h0001;
        tick(1, 1, 5'd5, 0);
        tick(0, 1, 0, 0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_exp", out_exp, 5);
        chk("post_rst_data", out_data[7], 16'h0020);
        tick(0, 1, 0, 0);

        for (int k = 0; k < 3000; k++) begin
            rand_stim();
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 16; i++) stim[i] = 16'($urandom_range(0, 7));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 5'($urandom), $urandom_range(0, 149) == 0);
        end
        for (int k = 0; k < 6; k++) tick(0, 1, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
